// File: rtl/deconv_layer.sv
// Transposed-convolution layer: streams an input frame in, scatter-accumulates
// each pixel times the kernel into an output accumulator array, then streams
// the shifted and saturated accumulators out in raster order.
module deconv_layer #(
  parameter int INPUT_SIZE     = 4,
  parameter int INPUT_CHANNELS = 3,
  parameter int KERNEL_SIZE    = 3,
  parameter int PX_SIZE        = 8,
  parameter int SHIFT          = 8
) (
  input  logic                                                                    clk,
  input  logic                                                                    rst_n,
  input  logic [KERNEL_SIZE-1:0][KERNEL_SIZE-1:0][INPUT_CHANNELS-1:0][PX_SIZE-1:0] kernel,
  input  logic                                                                    in_valid,
  output logic                                                                    in_ready,
  input  logic [INPUT_CHANNELS-1:0][PX_SIZE-1:0]                                  in_px,
  output logic                                                                    out_valid,
  input  logic                                                                    out_ready,
  output logic [PX_SIZE-1:0]                                                      out_px,
  output logic                                                                    out_last,
  output logic                                                                    busy
);

  localparam int OUTPUT_SIZE = INPUT_SIZE + KERNEL_SIZE - 1;
  localparam int ACC_W       = 2 * PX_SIZE + $clog2(INPUT_CHANNELS * KERNEL_SIZE * KERNEL_SIZE);
  localparam int IDX_W       = (OUTPUT_SIZE > 1) ? $clog2(OUTPUT_SIZE) : 1;

  localparam logic [IDX_W-1:0] IN_LAST  = IDX_W'(INPUT_SIZE - 1);
  localparam logic [IDX_W-1:0] OUT_LAST = IDX_W'(OUTPUT_SIZE - 1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

  typedef enum logic {ACCUM, DRAIN} state_t;

  state_t state_q, state_d;

  logic [ACC_W-1:0] acc_q [OUTPUT_SIZE][OUTPUT_SIZE];
  logic [ACC_W-1:0] acc_d [OUTPUT_SIZE][OUTPUT_SIZE];

  logic [KERNEL_SIZE-1:0][KERNEL_SIZE-1:0][INPUT_CHANNELS-1:0][PX_SIZE-1:0] kernel_q, kernel_d;
  logic [KERNEL_SIZE-1:0][KERNEL_SIZE-1:0][INPUT_CHANNELS-1:0][PX_SIZE-1:0] kernel_eff;

  logic [IDX_W-1:0] in_row_q, in_row_d, in_col_q, in_col_d;
  logic [IDX_W-1:0] out_row_q, out_row_d, out_col_q, out_col_d;
  logic             busy_q, busy_d;

  logic             in_fire, out_fire, first_px, last_in, last_out;
  logic [ACC_W-1:0] contrib [KERNEL_SIZE][KERNEL_SIZE];
  logic [ACC_W-1:0] shifted;

  assign first_px = (in_row_q == '0) && (in_col_q == '0);
  assign last_in  = (in_row_q == IN_LAST) && (in_col_q == IN_LAST);
  assign last_out = (out_row_q == OUT_LAST) && (out_col_q == OUT_LAST);
  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;

  // The first pixel of a frame sees the live kernel; the rest see the latched copy.
  assign kernel_eff = first_px ? kernel : kernel_q;

  // Per-tap channel dot product of the current pixel with the kernel.
  always_comb begin
    logic [ACC_W-1:0] sum;
    for (int unsigned i = 0; i < KERNEL_SIZE; i++) begin
      for (int unsigned j = 0; j < KERNEL_SIZE; j++) begin
        sum = '0;
        for (int unsigned c = 0; c < INPUT_CHANNELS; c++) begin
          sum = sum + ACC_W'(in_px[c]) * ACC_W'(kernel_eff[i][j][c]);
        end
        contrib[i][j] = sum;
      end
    end
  end

  // Next state of accumulators, kernel latch, raster counters and busy flag.
  always_comb begin
    logic [IDX_W-1:0] r_idx, c_idx;
    acc_d     = acc_q;
    kernel_d  = kernel_q;
    in_row_d  = in_row_q;
    in_col_d  = in_col_q;
    out_row_d = out_row_q;
    out_col_d = out_col_q;
    busy_d    = busy_q;
    r_idx     = '0;
    c_idx     = '0;
    if (in_fire) begin
      if (first_px) kernel_d = kernel;
      busy_d = 1'b1;
      for (int unsigned i = 0; i < KERNEL_SIZE; i++) begin
        for (int unsigned j = 0; j < KERNEL_SIZE; j++) begin
          r_idx = in_row_q + IDX_W'(i);
          c_idx = in_col_q + IDX_W'(j);
          acc_d[r_idx][c_idx] = acc_d[r_idx][c_idx] + contrib[i][j];
        end
      end
      if (in_col_q == IN_LAST) begin
        in_col_d = '0;
        in_row_d = (in_row_q == IN_LAST) ? '0 : in_row_q + IDX_ONE;
      end else begin
        in_col_d = in_col_q + IDX_ONE;
      end
    end
    if (out_fire) begin
      if (last_out) begin
        acc_d     = '{default: '0};
        out_row_d = '0;
        out_col_d = '0;
        in_row_d  = '0;
        in_col_d  = '0;
        busy_d    = 1'b0;
      end else if (out_col_q == OUT_LAST) begin
        out_col_d = '0;
        out_row_d = out_row_q + IDX_ONE;
      end else begin
        out_col_d = out_col_q + IDX_ONE;
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ACCUM;
    else        state_q <= state_d;
  end

  // FSM next state: leave ACCUM after the last input, DRAIN after the last output.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ACCUM:   if (in_fire && last_in)   state_d = DRAIN;
      DRAIN:   if (out_fire && last_out) state_d = ACCUM;
      default: state_d = ACCUM;
    endcase
  end

  // FSM outputs: handshake flags derive purely from the current state.
  always_comb begin
    in_ready  = (state_q == ACCUM);
    out_valid = (state_q == DRAIN);
    out_last  = (state_q == DRAIN) && last_out;
  end

  // Output pixel: shifted accumulator, saturated to the pixel range.
  always_comb begin
    shifted = acc_q[out_row_q][out_col_q] >> SHIFT;
    out_px  = (|shifted[ACC_W-1:PX_SIZE]) ? '1 : shifted[PX_SIZE-1:0];
  end

  assign busy = busy_q;

  // Datapath and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q     <= '{default: '0};
      kernel_q  <= '0;
      in_row_q  <= '0;
      in_col_q  <= '0;
      out_row_q <= '0;
      out_col_q <= '0;
      busy_q    <= 1'b0;
    end else begin
      acc_q     <= acc_d;
      kernel_q  <= kernel_d;
      in_row_q  <= in_row_d;
      in_col_q  <= in_col_d;
      out_row_q <= out_row_d;
      out_col_q <= out_col_d;
      busy_q    <= busy_d;
    end
  end

endmodule

// File: tb/tb_deconv_layer.sv
// Bench for deconv_layer: three instances sharing inputs and differing only in
// SHIFT (0, 8, 16), checked against constant vectors and a scatter-sum model.
module tb_deconv_layer;

  localparam int IS = 2;
  localparam int CH = 3;
  localparam int KS = 3;
  localparam int OS = IS + KS - 1;
  localparam int NB = OS * OS;

  typedef int kern_t  [KS][KS][CH];
  typedef int pix_t   [IS*IS][CH];
  typedef int frame_t [3][NB];

  typedef struct {
    string  name;
    kern_t  k;
    pix_t   p;
    frame_t exp;
  } vec_t;

  int SH [3] = '{0, 8, 16};

  logic clk = 1'b0;
  logic rst_n;
  logic [KS-1:0][KS-1:0][CH-1:0][7:0] kernel;
  logic in_valid, out_ready;
  logic [CH-1:0][7:0] in_px;
  logic [2:0] in_ready_v, out_valid_v, out_last_v, busy_v;
  logic [2:0][7:0] out_px_v;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  deconv_layer #(.INPUT_SIZE(IS), .INPUT_CHANNELS(CH), .KERNEL_SIZE(KS), .PX_SIZE(8), .SHIFT(0)) dut_a (
    .clk(clk), .rst_n(rst_n), .kernel(kernel), .in_valid(in_valid), .in_ready(in_ready_v[0]),
    .in_px(in_px), .out_valid(out_valid_v[0]), .out_ready(out_ready), .out_px(out_px_v[0]),
    .out_last(out_last_v[0]), .busy(busy_v[0]));

  deconv_layer #(.INPUT_SIZE(IS), .INPUT_CHANNELS(CH), .KERNEL_SIZE(KS), .PX_SIZE(8), .SHIFT(8)) dut_b (
    .clk(clk), .rst_n(rst_n), .kernel(kernel), .in_valid(in_valid), .in_ready(in_ready_v[1]),
    .in_px(in_px), .out_valid(out_valid_v[1]), .out_ready(out_ready), .out_px(out_px_v[1]),
    .out_last(out_last_v[1]), .busy(busy_v[1]));

  deconv_layer #(.INPUT_SIZE(IS), .INPUT_CHANNELS(CH), .KERNEL_SIZE(KS), .PX_SIZE(8), .SHIFT(16)) dut_c (
    .clk(clk), .rst_n(rst_n), .kernel(kernel), .in_valid(in_valid), .in_ready(in_ready_v[2]),
    .in_px(in_px), .out_valid(out_valid_v[2]), .out_ready(out_ready), .out_px(out_px_v[2]),
    .out_last(out_last_v[2]), .busy(busy_v[2]));

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: every input pixel scatters pixel*weight over a KSxKS window.
  function automatic void model(input kern_t k, input pix_t p, output frame_t e);
    longint acc [OS][OS];
    longint v;
    foreach (acc[r, s]) acc[r][s] = 0;
    for (int x = 0; x < IS; x++)
      for (int y = 0; y < IS; y++)
        for (int i = 0; i < KS; i++)
          for (int j = 0; j < KS; j++)
            for (int c = 0; c < CH; c++)
              acc[x+i][y+j] += longint'(p[x*IS+y][c]) * longint'(k[i][j][c]);
    for (int n = 0; n < 3; n++)
      for (int r = 0; r < OS; r++)
        for (int s = 0; s < OS; s++) begin
          v = acc[r][s] >> SH[n];
          e[n][r*OS+s] = (v > 255) ? 255 : int'(v);
        end
  endfunction

  task automatic set_kernel(input kern_t k);
    for (int i = 0; i < KS; i++)
      for (int j = 0; j < KS; j++)
        for (int c = 0; c < CH; c++)
          kernel[i][j][c] = 8'(k[i][j][c]);
  endtask

  task automatic feed(input pix_t p, input int gap, input bit kchg, input kern_t knew);
    int idx = 0;
    int cyc = 0;
    bit fire;
    while (idx < IS*IS && cyc < 500) begin
      for (int c = 0; c < CH; c++) in_px[c] = 8'(p[idx][c]);
      in_valid = (gap == 0) || ($urandom_range(99) >= gap);
      fire = in_valid && in_ready_v[0];
      @(posedge clk); #1;
      cyc++;
      if (fire) begin
        idx++;
        if (idx == 1) begin
          chk("busy_after_first_px", busy_v, 7);
          if (kchg) set_kernel(knew);
        end
      end
    end
    in_valid = 1'b0;
    chk("feed_pixels_accepted", idx, IS*IS);
    chk("out_valid_after_last_input", out_valid_v, 7);
  endtask

  task automatic drain(input int stall, input int rst_at, output frame_t got);
    int beats = 0;
    int cyc = 0;
    bit rdy;
    logic [2:0][7:0] held;
    foreach (got[n, b]) got[n][b] = -1;
    while (beats < NB && cyc < 1000) begin
      if (rst_at == beats) begin
        rst_n = 1'b0;
        #1;
        chk("rst_out_valid", out_valid_v, 0);
        chk("rst_busy", busy_v, 0);
        chk("rst_in_ready", in_ready_v, 7);
        chk("rst_out_last", out_last_v, 0);
        in_valid = 1'b0;
        out_ready = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        return;
      end
      out_ready = (stall == 0) || ($urandom_range(99) >= stall);
      in_valid = 1'($urandom_range(1));
      in_px = 24'($urandom);
      chk("drain_out_valid", out_valid_v, 7);
      chk("drain_in_ready", in_ready_v, 0);
      chk("drain_busy", busy_v, 7);
      chk($sformatf("out_last_b%0d", beats), out_last_v, (beats == NB-1) ? 7 : 0);
      rdy = out_ready;
      held = out_px_v;
      if (rdy) for (int n = 0; n < 3; n++) got[n][beats] = int'(out_px_v[n]);
      @(posedge clk); #1;
      cyc++;
      if (rdy) beats++;
      else chk("stall_out_px_stable", out_px_v, held);
    end
    out_ready = 1'b0;
    in_valid = 1'b0;
    chk("drain_beat_count", beats, NB);
    chk("post_frame_in_ready", in_ready_v, 7);
    chk("post_frame_out_valid", out_valid_v, 0);
    chk("post_frame_busy", busy_v, 0);
  endtask

  task automatic chk_frame(input string name, input frame_t got, input frame_t exp);
    for (int n = 0; n < 3; n++)
      for (int b = 0; b < NB; b++)
        chk($sformatf("%s_sh%0d_b%0d", name, SH[n], b), got[n][b], exp[n][b]);
  endtask

  initial begin
    vec_t   tbl [3];
    kern_t  kz, k1, k2, k3, kr, kn;
    pix_t   pz, pr;
    frame_t fz, got, e;
    int imp_exp [NB] = '{1,2,3,0, 4,5,6,0, 7,8,9,0, 0,0,0,0};
    int ovl_exp [NB] = '{1,2,2,1, 2,4,4,2, 2,4,4,2, 1,2,2,1};

    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    in_px = '0;
    kernel = '0;

    foreach (kz[i, j, c]) begin kz[i][j][c] = 0; k1[i][j][c] = 0; k2[i][j][c] = 0; k3[i][j][c] = 0; end
    foreach (pz[i, c]) pz[i][c] = 0;
    foreach (fz[n, b]) fz[n][b] = 0;
    for (int i = 0; i < KS; i++)
      for (int j = 0; j < KS; j++) begin
        k1[i][j][0] = 1;
        k2[i][j][0] = 2;
        k3[i][j][0] = 3;
      end

    // Constant vectors: impulse, overlap sum, saturation / shift.
    tbl[0].name = "impulse";  tbl[0].k = kz; tbl[0].p = pz; tbl[0].exp = fz;
    for (int i = 0; i < KS; i++) for (int j = 0; j < KS; j++) tbl[0].k[i][j][0] = 3*i + j + 1;
    tbl[0].p[0][0] = 1;
    for (int b = 0; b < NB; b++) tbl[0].exp[0][b] = imp_exp[b];

    tbl[1].name = "overlap";  tbl[1].k = k1; tbl[1].p = pz; tbl[1].exp = fz;
    for (int i = 0; i < IS*IS; i++) tbl[1].p[i][0] = 1;
    for (int b = 0; b < NB; b++) tbl[1].exp[0][b] = ovl_exp[b];

    tbl[2].name = "saturate"; tbl[2].k = kz; tbl[2].p = pz; tbl[2].exp = fz;
    foreach (tbl[2].k[i, j, c]) tbl[2].k[i][j][c] = 255;
    for (int c = 0; c < CH; c++) tbl[2].p[0][c] = 255;
    for (int r = 0; r < KS; r++)
      for (int s = 0; s < KS; s++) begin
        tbl[2].exp[0][r*OS+s] = 255;
        tbl[2].exp[1][r*OS+s] = 255;
        tbl[2].exp[2][r*OS+s] = 2;
      end

    repeat (3) @(posedge clk);
    #1;
    chk("reset_in_ready", in_ready_v, 7);
    chk("reset_out_valid", out_valid_v, 0);
    chk("reset_out_last", out_last_v, 0);
    chk("reset_busy", busy_v, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int v = 0; v < 3; v++) begin
      set_kernel(tbl[v].k);
      feed(tbl[v].p, 0, 1'b0, kz);
      drain(0, -1, got);
      chk_frame(tbl[v].name, got, tbl[v].exp);
    end

    // Backpressure on both sides with the impulse frame.
    set_kernel(tbl[0].k);
    feed(tbl[0].p, 40, 1'b0, kz);
    drain(50, -1, got);
    chk_frame("backpressure", got, tbl[0].exp);

    // Reset while the fifth output beat is presented, then a clean overlap frame.
    set_kernel(tbl[0].k);
    feed(tbl[0].p, 0, 1'b0, kz);
    drain(0, 4, got);
    set_kernel(k1);
    feed(tbl[1].p, 0, 1'b0, kz);
    drain(0, -1, got);
    chk_frame("after_reset", got, tbl[1].exp);

    // Back-to-back frames; kernel edits after each first pixel must not matter.
    set_kernel(k1);
    feed(tbl[1].p, 0, 1'b1, k3);
    drain(30, -1, got);
    chk_frame("b2b_frame1", got, tbl[1].exp);
    set_kernel(k1);
    feed(tbl[1].p, 0, 1'b1, k2);
    drain(0, -1, got);
    chk_frame("b2b_frame2", got, tbl[1].exp);

    // Random frames against the scatter-sum model.
    for (int f = 0; f < 6; f++) begin
      foreach (kr[i, j, c]) begin
        kr[i][j][c] = $urandom_range(255);
        kn[i][j][c] = $urandom_range(255);
      end
      foreach (pr[i, c]) pr[i][c] = $urandom_range(255);
      model(kr, pr, e);
      set_kernel(kr);
      feed(pr, $urandom_range(50), 1'b1, kn);
      drain($urandom_range(50), -1, got);
      chk_frame($sformatf("random%0d", f), got, e);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
